alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one 32-bit ALU (yAlu) between two requesters under a round-robin grant.
- Each requester issues an operation with operands a, b and a 3-bit op through a valid/ready handshake.
- The block latches the operands, drives the ALU, registers the result and returns it on a single response channel tagged with the requester id.
- It sits between the register-read stage of the two client datapaths and the shared ALU.

Parameters:
- W, 32, operand/result width (fixed at 32 because yAlu is 32-bit; only 32 is supported).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  W  requester 0 operand a (two's-complement).
- req0_b  input  W  requester 0 operand b.
- req0_op  input  3  requester 0 ALU op.
- req1_valid / req1_ready / req1_a / req1_b / req1_op: same as requester 0, for requester 1.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  1  originating requester (0/1).
- rsp_z  output  W  ALU result.
- rsp_zero  output  1  rsp_z == 0.
- rsp_err  output  1  op was not a legal code.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset, sampled on the rising edge of clk.
- Legal ops:
  - 000 AND
  - 001 OR
  - 010 ADD (mod 2^32)
  - 110 SUB (mod 2^32)
  - 111 SLT: signed compare, z = 1 if a < b else 0.
- Illegal ops (011, 100, 101): rsp_z = 0, rsp_zero = 1, rsp_err = 1. The op is still consumed and answered, with no hang.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational and asserted only for the granted requester, and only when its valid is high.
  - Grant when one valid is high: that requester.
  - Grant when both are high: the requester selected by the rr pointer.
  - On handshake: latch a, b, op and id into the operand registers; go to EXEC.
  - The rr pointer then points to the other requester.
- EXEC (one cycle): the ALU sees the latched operands. At the clock edge, capture z, the zero flag and the err flag into the response registers; go to RESP.
- RESP:
  - rsp_valid = 1. rsp_* stay stable until rsp_valid & rsp_ready.
  - On that handshake, go to IDLE. The next grant happens in the following cycle, so there is no same-cycle re-grant.
- Both reqN_ready are 0 in EXEC and RESP. Requesters hold valid and payload until they see ready.
- Latency: accept at edge N, rsp_valid high from edge N+2. Peak throughput is one op per 3 cycles with rsp_ready held high.
- rr pointer reset value is 0, so requester 0 wins the first tie.
- A lone requester is granted regardless of the pointer; the pointer still toggles after every grant.
- Reset values:
  - state IDLE, rr pointer 0.
  - rsp_valid 0, rsp_id 0, rsp_z 0, rsp_zero 0, rsp_err 0.
  - req0_ready 0, req1_ready 0.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded with no response, and the block returns to IDLE next cycle.
- Requester payload changes while not ready have no effect.
- Valid dropped without a handshake is allowed and is treated as withdrawn.
- The ALU is purely combinational. All block outputs except reqN_ready are registered.

Decomposition:
- Shared package/include holds:
  - op code constants: OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b110, OP_SLT = 3'b111.
  - FSM state encodings: IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2.
- Natural sub-module: the existing yAlu, instantiated once (z, ex, a, b, op). Its ex output feeds rsp_zero.
- The legality check is a small local decode in alu_arbiter.

Test Plan:
- Single request: req0 a=5, b=3, op=010 -> req0_ready at accept cycle; two edges later rsp_valid=1, rsp_id=0, rsp_z=8, rsp_zero=0, rsp_err=0.
- Signed SLT and SUB on req1: a=32'hFFFFFFFF (-1), b=1, op=111 -> rsp_z=1. Then a=7, b=7, op=110 -> rsp_z=0, rsp_zero=1.
- Simultaneous valids right after reset: req0 op=000 (a=32'hF0F0F0F0, b=32'hFF00FF00), req1 op=001 (same a, b). Required order:
  - first response rsp_id=0, rsp_z=32'hF000F000;
  - second response rsp_id=1, rsp_z=32'hFFF0FFF0;
  - third tie goes to req0 again.
- Backpressure: hold rsp_ready=0 for 4 cycles in RESP -> rsp_* stable, both reqN_ready=0. Raise rsp_ready -> handshake, IDLE next cycle.
- Illegal op 101 from req0 -> rsp_z=0, rsp_zero=1, rsp_err=1, block not stuck; a following op=010 a=1, b=1 returns 2.
- Assert reset during EXEC -> no rsp_valid is produced; next cycle all outputs are at reset values; the next tie grants req0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op codes, FSM states
// and the fixed datapath width of the shared ALU.
package alu_arbiter_pkg;

  localparam int ALU_W = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_yalu.sv
// The shared 32-bit combinational ALU; unknown op codes produce zero, and ex
// flags a zero result.
module yAlu
  import alu_arbiter_pkg::*;
#(
  parameter int W = ALU_W
) (
  output logic [W-1:0] z,
  output logic         ex,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op
);

  always_comb begin
    z = '0;
    case (op)
      OP_AND:  z = a & b;
      OP_OR:   z = a | b;
      OP_ADD:  z = a + b;
      OP_SUB:  z = a - b;
      OP_SLT:  z = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: z = '0;
    endcase
  end

  assign ex = (z == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one yAlu between two requesters; one op in flight,
// answered on a single registered response channel tagged with the requester id.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [2:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [2:0]   req1_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_z,
  output logic         rsp_zero,
  output logic         rsp_err
);

  state_t         r_state;
  state_t         w_nextState;
  logic           r_rr;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [2:0]     r_op;
  logic           r_id;
  logic           r_rspValid;
  logic           r_rspId;
  logic [W-1:0]   r_rspZ;
  logic           r_rspZero;
  logic           r_rspErr;

  logic           w_grant0;
  logic           w_grant1;
  logic           w_open;
  logic           w_accept;
  logic           w_legal;
  logic [W-1:0]   w_z;
  logic           w_ex;

  // A lone valid always wins; on a tie the rr pointer picks the requester.
  assign w_grant1   = req1_valid & (~req0_valid | r_rr);
  assign w_grant0   = req0_valid & ~w_grant1;
  assign w_open     = (r_state == IDLE) & ~reset;
  assign req0_ready = w_open & w_grant0;
  assign req1_ready = w_open & w_grant1;
  assign w_accept   = req0_ready | req1_ready;

  always_comb begin
    w_legal = 1'b0;
    case (r_op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: w_legal = 1'b1;
      default:                               w_legal = 1'b0;
    endcase
  end

  yAlu #(.W(W)) uAlu (
    .z  (w_z),
    .ex (w_ex),
    .a  (r_a),
    .b  (r_b),
    .op (r_op)
  );

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = EXEC;
      EXEC:    w_nextState = RESP;
      RESP:    if (rsp_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rr       <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= OP_AND;
      r_id       <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspId    <= 1'b0;
      r_rspZ     <= '0;
      r_rspZero  <= 1'b0;
      r_rspErr   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_a  <= w_grant1 ? req1_a  : req0_a;
        r_b  <= w_grant1 ? req1_b  : req0_b;
        r_op <= w_grant1 ? req1_op : req0_op;
        r_id <= w_grant1;
        r_rr <= ~r_rr;
      end
      // Illegal ops are still answered, forced to a zero result with err set.
      if (r_state == EXEC) begin
        r_rspValid <= 1'b1;
        r_rspId    <= r_id;
        r_rspZ     <= w_legal ? w_z : '0;
        r_rspZero  <= w_legal ? w_ex : 1'b1;
        r_rspErr   <= ~w_legal;
      end else if ((r_state == RESP) && rsp_ready) begin
        r_rspValid <= 1'b0;
      end
    end
  end

  assign rsp_valid = r_rspValid;
  assign rsp_id    = r_rspId;
  assign rsp_z     = r_rspZ;
  assign rsp_zero  = r_rspZero;
  assign rsp_err   = r_rspErr;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: arbitration order, ALU results,
// backpressure, illegal ops and reset in the middle of an operation.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [31:0] rsp_z;

  int nChecks = 0;
  int nBad    = 0;

  alu_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_z      (rsp_z),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input int id, input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] op);
    if (id == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rspValid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_rspId"},    32'(rsp_id),    32'd0);
    checkOutput({tag, "_rspZ"},     rsp_z,          32'd0);
    checkOutput({tag, "_rspZero"},  32'(rsp_zero),  32'd0);
    checkOutput({tag, "_rspErr"},   32'(rsp_err),   32'd0);
    checkOutput({tag, "_rdy0"},     32'(req0_ready), 32'd0);
    checkOutput({tag, "_rdy1"},     32'(req1_ready), 32'd0);
  endtask

  // Issue one op from a lone requester, then wait for and check its response.
  task automatic applyStimulus(input string tag, input int id, input logic [31:0] a,
                               input logic [31:0] b, input logic [2:0] op,
                               input logic [31:0] expZ, input logic expZero,
                               input logic expErr);
    logic got;
    got = 1'b0;
    setReq(id, 1'b1, a, b, op);
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      got = (id == 0) ? req0_ready : req1_ready;
      @(negedge clk);
    end
    setReq(id, 1'b0, 32'd0, 32'd0, 3'd0);
    checkOutput({tag, "_accept"}, 32'(got), 32'd1);
    for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
    checkOutput({tag, "_rspValid"}, 32'(rsp_valid), 32'd1);
    checkOutput({tag, "_rspId"},    32'(rsp_id),    32'(id));
    checkOutput({tag, "_rspZ"},     rsp_z,          expZ);
    checkOutput({tag, "_rspZero"},  32'(rsp_zero),  32'(expZero));
    checkOutput({tag, "_rspErr"},   32'(rsp_err),   32'(expErr));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput({tag, "_drained"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    rsp_ready = 1'b0;
    setReq(0, 1'b0, 32'd0, 32'd0, 3'd0);
    setReq(1, 1'b0, 32'd0, 32'd0, 3'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkResetState("reset");

    // Tie right after reset: req0 first, then req1.
    @(negedge clk);
    setReq(0, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 3'b000);
    setReq(1, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 3'b001);
    #1;
    checkOutput("tie1_rdy0", 32'(req0_ready), 32'd1);
    checkOutput("tie1_rdy1", 32'(req1_ready), 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    checkOutput("exec_rdy0", 32'(req0_ready), 32'd0);
    checkOutput("exec_rdy1", 32'(req1_ready), 32'd0);
    checkOutput("exec_rspValid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    checkOutput("tie1_rspValid", 32'(rsp_valid), 32'd1);
    checkOutput("tie1_rspId",    32'(rsp_id),    32'd0);
    checkOutput("tie1_rspZ",     rsp_z,          32'hF000F000);

    // Backpressure: response held stable, no grants while waiting.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("bp_rspValid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_rspZ",     rsp_z,          32'hF000F000);
      checkOutput("bp_rspId",    32'(rsp_id),    32'd0);
      checkOutput("bp_rdy1",     32'(req1_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checkOutput("bp_drained", 32'(rsp_valid), 32'd0);
    checkOutput("tie2_rdy1",  32'(req1_ready), 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("tie2_rspValid", 32'(rsp_valid), 32'd1);
    checkOutput("tie2_rspId",    32'(rsp_id),    32'd1);
    checkOutput("tie2_rspZ",     rsp_z,          32'hFFF0FFF0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Third tie returns to req0.
    setReq(0, 1'b1, 32'd4, 32'd6, 3'b010);
    setReq(1, 1'b1, 32'd9, 32'd9, 3'b010);
    #1;
    checkOutput("tie3_rdy0", 32'(req0_ready), 32'd1);
    checkOutput("tie3_rdy1", 32'(req1_ready), 32'd0);
    @(negedge clk);
    setReq(0, 1'b0, 32'd0, 32'd0, 3'd0);
    setReq(1, 1'b0, 32'd0, 32'd0, 3'd0);
    repeat (2) @(negedge clk);
    checkOutput("tie3_rspId", 32'(rsp_id), 32'd0);
    checkOutput("tie3_rspZ",  rsp_z,       32'd10);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    applyStimulus("add5_3",  0, 32'd5,        32'd3, 3'b010, 32'd8, 1'b0, 1'b0);
    applyStimulus("slt_neg", 1, 32'hFFFFFFFF, 32'd1, 3'b111, 32'd1, 1'b0, 1'b0);
    applyStimulus("sub_eq",  1, 32'd7,        32'd7, 3'b110, 32'd0, 1'b1, 1'b0);
    applyStimulus("illegal", 0, 32'd12,       32'd3, 3'b101, 32'd0, 1'b1, 1'b1);
    applyStimulus("add1_1",  0, 32'd1,        32'd1, 3'b010, 32'd2, 1'b0, 1'b0);

    // Reset while an op is in EXEC: it must vanish without a response.
    setReq(0, 1'b1, 32'd3, 32'd3, 3'b010);
    #1;
    checkOutput("rst_accept", 32'(req0_ready), 32'd1);
    @(negedge clk);
    setReq(0, 1'b0, 32'd0, 32'd0, 3'd0);
    reset = 1'b1;
    @(negedge clk);
    checkResetState("rstExec");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_noRsp", 32'(rsp_valid), 32'd0);
    end
    setReq(0, 1'b1, 32'd1, 32'd2, 3'b001);
    setReq(1, 1'b1, 32'd1, 32'd2, 3'b000);
    #1;
    checkOutput("rstTie_rdy0", 32'(req0_ready), 32'd1);
    checkOutput("rstTie_rdy1", 32'(req1_ready), 32'd0);
    @(negedge clk);
    setReq(0, 1'b0, 32'd0, 32'd0, 3'd0);
    setReq(1, 1'b0, 32'd0, 32'd0, 3'd0);
    repeat (2) @(negedge clk);
    checkOutput("rstTie_rspId", 32'(rsp_id), 32'd0);
    checkOutput("rstTie_rspZ",  rsp_z,       32'd3);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
